// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, halt address, fetch FSM states
// and the byte-swap helper used by the optional endian swap.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: reads one word at RegPC over an Avalon-style master into the
// instruction register. Define IFETCH_ENDIAN_SWAP_EN to byte-reverse captured data.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] instr,
  output logic              fetch_done,
  output logic              halted,
  output logic              misaligned
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              halted_q, halted_d;
  logic              misaligned_q, misaligned_d;
  logic [DATA_W-1:0] rd_word;

`ifdef IFETCH_ENDIAN_SWAP_EN
  assign rd_word = byte_swap32(avm_readdata);
`else
  assign rd_word = avm_readdata;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Halt address is checked before alignment so PC 0 always reports halted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (pc == HALT_ADDR)        state_d = HALT;
          else if (pc[1:0] != 2'b00) state_d = HALT;
          else                       state_d = READ;
        end
      end
      READ:    if (!avm_waitrequest) state_d = DONE;
      DONE:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    avm_read       = (state_q == READ);
    avm_byteenable = (state_q == READ) ? 4'b1111 : 4'b0000;
    fetch_done     = (state_q == DONE);
  end

  always_comb begin
    addr_d       = addr_q;
    instr_d      = instr_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    if (state_q == IDLE && fetch_req) begin
      if (pc == HALT_ADDR)        halted_d     = 1'b1;
      else if (pc[1:0] != 2'b00) misaligned_d = 1'b1;
      else                       addr_d       = pc;
    end
    if (state_q == READ && !avm_waitrequest) instr_d = rd_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      instr_q      <= '0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign avm_address = addr_q;
  assign instr       = instr_q;
  assign halted      = halted_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] instr;
  logic        fetch_done;
  logic        halted;
  logic        misaligned;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_req      (fetch_req),
    .pc             (pc),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .instr          (instr),
    .fetch_done     (fetch_done),
    .halted         (halted),
    .misaligned     (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Model of what the instruction register should hold for a bus word.
  function automatic logic [31:0] model_word(input logic [31:0] rd);
    logic [31:0] r;
    r = rd;
`ifdef IFETCH_ENDIAN_SWAP_EN
    for (int b = 0; b < 4; b++) r[8*b +: 8] = rd[8*(3-b) +: 8];
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_aligned();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if (a == 32'h0) a = 32'h4;
    return a;
  endfunction

  // One complete fetch: request, nwait stalled cycles, then data.
  task automatic do_fetch(input logic [31:0] addr, input int nwait, input logic [31:0] data);
    @(negedge clk);
    fetch_req       = 1'b1;
    pc              = addr;
    avm_waitrequest = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    pc        = $urandom;
    for (int w = 0; w <= nwait; w++) begin
      chk("read_strobe", avm_read, 1);
      chk("read_addr", avm_address, addr);
      chk("read_be", avm_byteenable, 4'hF);
      chk("done_early", fetch_done, 0);
      chk("instr_hold", instr, exp_instr);
      avm_waitrequest = (w < nwait);
      avm_readdata    = (w < nwait) ? $urandom : data;
      @(posedge clk);
      @(negedge clk);
    end
    exp_instr = model_word(data);
    chk("done_pulse", fetch_done, 1);
    chk("done_read", avm_read, 0);
    chk("done_be", avm_byteenable, 4'h0);
    chk("done_addr", avm_address, addr);
    chk("instr", instr, exp_instr);
    avm_waitrequest = 1'($urandom_range(0, 1));
    avm_readdata    = $urandom;
    @(posedge clk);
    @(negedge clk);
    chk("done_once", fetch_done, 0);
    chk("idle_read", avm_read, 0);
    chk("idle_addr", avm_address, addr);
  endtask

  // Request at a halting PC; the block must freeze with no bus activity.
  task automatic do_stop(input logic [31:0] addr, input logic exp_halt, input logic exp_mis);
    @(negedge clk);
    fetch_req = 1'b1;
    pc        = addr;
    @(posedge clk);
    @(negedge clk);
    chk("halted", halted, 32'(exp_halt));
    chk("misaligned", misaligned, 32'(exp_mis));
    for (int i = 0; i < 5; i++) begin
      chk("stop_read", avm_read, 0);
      chk("stop_be", avm_byteenable, 4'h0);
      chk("stop_done", fetch_done, 0);
      chk("stop_instr", instr, exp_instr);
      pc = rand_aligned();
      @(posedge clk);
      @(negedge clk);
    end
    fetch_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    fetch_req = 1'b0;
    #1;
    exp_instr = 32'h0;
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_be", avm_byteenable, 4'h0);
    chk("rst_instr", instr, 0);
    chk("rst_done", fetch_done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mis", misaligned, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    fetch_req       = 1'b0;
    pc              = 32'h0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h0;
    exp_instr       = 32'h0;
    repeat (3) @(posedge clk);
    apply_reset();

    do_fetch(32'hBFC00000, 0, 32'h10650005);
    do_fetch(32'hBFC00004, 3, 32'h04A10004);
    do_fetch(32'hBFC00008, 0, 32'h09000008);
`ifdef IFETCH_ENDIAN_SWAP_EN
    chk("endian_swap", instr, 32'h08000009);
`else
    chk("endian_plain", instr, 32'h09000008);
`endif

    for (int n = 0; n < 25; n++)
      do_fetch(rand_aligned(), int'($urandom_range(0, 4)), $urandom);

    do_stop(32'h0, 1'b1, 1'b0);
    apply_reset();
    do_fetch(rand_aligned(), 1, $urandom);
    do_stop(32'hBFC00002, 1'b0, 1'b1);
    apply_reset();
    do_stop((rand_aligned() | 32'h3), 1'b0, 1'b1);
    apply_reset();

    // Reset dropped in the middle of a stalled read.
    do_fetch(32'hBFC00020, 0, 32'h12345678);
    @(negedge clk);
    fetch_req       = 1'b1;
    pc              = 32'hBFC00024;
    avm_waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    chk("midrd_read", avm_read, 1);
    #2;
    reset = 1'b0;
    #1;
    exp_instr = 32'h0;
    chk("midrd_rst_read", avm_read, 0);
    chk("midrd_rst_instr", instr, 0);
    chk("midrd_rst_be", avm_byteenable, 4'h0);
    @(negedge clk);
    reset           = 1'b1;
    avm_waitrequest = 1'b0;
    do_fetch(32'hBFC00000, 2, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
